// File: rtl/laser_btn_conditioner_pkg.sv
// Shared definitions for the laser button conditioner and laser timer:
// FSM state encodings, default debounce/lockout lengths and the laser on-time.
package laser_btn_conditioner_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEB_P = 3'd1,
        S_FIRE  = 3'd2,
        S_HELD  = 3'd3,
        S_DEB_R = 3'd4
    } state_t;

    localparam int LASER_ON_CYCLES     = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 8;
    // Lockout covers the laser on-time so retriggers while firing are dropped.
    localparam int LOCKOUT_CYCLES_DEF  = LASER_ON_CYCLES;

endpackage

// File: rtl/laser_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module laser_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    assign q = s2_reg;

endmodule

// File: rtl/laser_btn_conditioner.sv
// Synchronizes and debounces the raw laser push-button into a one-cycle start pulse B.
// Optional post-pulse retrigger lockout is compiled in with LASER_BTN_LOCKOUT_EN.
module laser_btn_conditioner
    import laser_btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 8,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnRaw,
    output logic B,
    output logic Busy
);

    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || LOCKOUT_CYCLES < 1 ||
        CNT_W < 1 || CNT_W > 16 || (DEBOUNCE_CYCLES - 1) > ((1 << CNT_W) - 1)) begin : g_bad_params
        $error("laser_btn_conditioner: illegal DEBOUNCE_CYCLES/CNT_W/LOCKOUT_CYCLES");
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             b_reg;
    logic             busy_reg;
    logic             sync;
    logic             lock_active;
    logic             lock_busy_next;

    laser_sync2 u_sync (
        .clk   (Clk),
        .rst_n (Rst),
        .d     (BtnRaw),
        .q     (sync)
    );

`ifdef LASER_BTN_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [LOCK_W-1:0] lock_reg, lock_next;

    always_comb begin
        lock_next = lock_reg;
        if (state_next == S_FIRE) begin
            lock_next = LOCK_W'(LOCKOUT_CYCLES);
        end else if (lock_reg != '0) begin
            lock_next = lock_reg - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lock_reg <= '0;
        end else begin
            lock_reg <= lock_next;
        end
    end

    assign lock_active    = (lock_reg != '0);
    assign lock_busy_next = (lock_next != '0);
`else
    assign lock_active    = 1'b0;
    assign lock_busy_next = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (sync && !lock_active) begin
                    cnt_next   = DEB_LOAD;
                    state_next = S_DEB_P;
                end
            end
            S_DEB_P: begin
                if (!sync) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = S_FIRE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_FIRE: begin
                state_next = S_HELD;
            end
            S_HELD: begin
                if (!sync) begin
                    cnt_next   = DEB_LOAD;
                    state_next = S_DEB_R;
                end
            end
            S_DEB_R: begin
                if (sync) begin
                    state_next = S_HELD;
                end else if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // B and Busy are registered from the next state so they line up with state_reg.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            b_reg     <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            b_reg     <= (state_next == S_FIRE);
            busy_reg  <= (state_next != S_IDLE) || lock_busy_next;
        end
    end

    assign B    = b_reg;
    assign Busy = busy_reg;

endmodule

// File: tb/tb_laser_btn_conditioner.sv
// Randomized scoreboard bench for laser_btn_conditioner against a run-length reference model.
module tb_laser_btn_conditioner;

    localparam int DEB  = 4;
    localparam int LOCK = 16;
`ifdef LASER_BTN_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic BtnRaw = 1'b1;
    logic B;
    logic Busy;

    laser_btn_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (8),
        .LOCKOUT_CYCLES  (LOCK)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .BtnRaw (BtnRaw),
        .B      (B),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic b;
        logic busy;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_pulses = 0;
    int   seen_pulses = 0;

    // Reference: raw samples delayed two edges; a press fires once the
    // synchronized level has been high on DEB+1 consecutive armed edges,
    // the edge after a pulse is dead, and a release re-arms after DEB+1 lows.
    bit m_s1, m_s2, m_fire, m_held;
    int m_run, m_lock;

    task automatic model_edge(input logic raw, input logic rst_v);
        exp_t e;
        bit   sync;
        bit   b;
        int   lock_prev;
        cyc++;
        if (!rst_v) begin
            m_s1 = 0; m_s2 = 0; m_fire = 0; m_held = 0; m_run = 0; m_lock = 0;
            e = '{b: 1'b0, busy: 1'b0, cyc: cyc};
            exp_q.push_back(e);
            return;
        end
        sync = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        b = 0;
        lock_prev = m_lock;
        if (m_fire) begin
            m_fire = 0;
            m_held = 1;
            m_run  = 0;
        end else if (m_held) begin
            m_run = sync ? 0 : m_run + 1;
            if (m_run == DEB + 1) begin
                m_held = 0;
                m_run  = 0;
            end
        end else if (!(LOCK_EN && lock_prev != 0 && m_run == 0)) begin
            if (sync) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_fire = 1;
                    b      = 1;
                    m_run  = 0;
                    exp_pulses++;
                end
            end else begin
                m_run = 0;
            end
        end
        if (LOCK_EN) begin
            if (b) m_lock = LOCK;
            else if (m_lock > 0) m_lock--;
        end
        e.b    = b;
        e.busy = m_fire || m_held || (m_run > 0) || (m_lock != 0);
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic raw, input logic rst_v);
        @(negedge Clk);
        #2;
        BtnRaw = raw;
        Rst    = rst_v;
        @(posedge Clk);
        model_edge(raw, rst_v);
    endtask

    task automatic steps(input logic raw, input int n);
        repeat (n) step(raw, 1'b1);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic step_async_rst(input logic raw);
        @(negedge Clk);
        #2;
        BtnRaw = raw;
        Rst    = 1'b0;
        #1;
        checks++;
        if (B !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset cyc %0d: B=%b Busy=%b required B=0 Busy=0", cyc, B, Busy);
        end
        @(posedge Clk);
        model_edge(raw, 1'b0);
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge Clk);
                if (B === 1'b1) seen_pulses++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (B !== e.b || Busy !== e.busy) begin
                        errors++;
                        $display("FAIL cycle_outputs cyc %0d: B=%b Busy=%b required B=%b Busy=%b",
                                 e.cyc, B, Busy, e.b, e.busy);
                    end else if (e.b) begin
                        $display("pulse cyc %0d B=1 Busy=%b", e.cyc, Busy);
                    end
                end
            end
        join_none

        // Reset held with button pressed, then release with button still held.
        repeat (3) step(1'b1, 1'b0);
        steps(1'b1, 20);
        steps(1'b0, 12);

        // Clean press.
        steps(1'b0, 5);
        steps(1'b1, 40);
        steps(1'b0, 12);

        // Press bounce, then settle.
        steps(1'b1, 2); steps(1'b0, 2); steps(1'b1, 2); steps(1'b0, 2);
        steps(1'b1, 20);
        // Release bounce, then clean release and re-press.
        steps(1'b0, 2);
        steps(1'b1, 10);
        steps(1'b0, 12);
        steps(1'b1, 15);
        steps(1'b0, 12);

        // Reset mid-debounce.
        steps(1'b1, 4);
        step_async_rst(1'b1);
        step(1'b1, 1'b0);
        steps(1'b0, 10);

        // Quick re-press shortly after the pulse, then one well after it.
        steps(1'b1, 8);
        steps(1'b0, 7);
        steps(1'b1, 12);
        steps(1'b0, 12);
        steps(1'b1, 30);
        steps(1'b0, 12);

        // Random bursts with occasional asynchronous resets.
        repeat (250) begin
            int   len;
            logic v;
            len = $urandom_range(1, 14);
            v   = 1'($urandom_range(0, 1));
            steps(v, len);
            if ($urandom_range(0, 39) == 0) begin
                step_async_rst(v);
                step(v, 1'b0);
            end
        end
        steps(1'b0, 12);

        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        checks++;
        if (seen_pulses != exp_pulses) begin
            errors++;
            $display("FAIL pulse_count: saw %0d pulses, required %0d", seen_pulses, exp_pulses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
